// File: rtl/sram_init_bridge.sv
// Bridge between the fabric SRAM port and the 1024x32 macro: clears the macro after
// reset, then forwards fabric accesses once configured and holds read data between reads.
module sram_init_bridge #(
  parameter int unsigned          ADDR_W         = 10,
  parameter int unsigned          DATA_W         = 32,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0]    INIT_VALUE     = '0
) (
  input  logic              UserCLK,
  input  logic              reset,
  input  logic              CONFIGURED,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic [DATA_W-1:0] fab_din,
  input  logic [DATA_W-1:0] fab_bm,
  input  logic              fab_wen,
  input  logic              fab_men,
  input  logic              fab_ren,
  output logic [DATA_W-1:0] fab_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] mem_bm,
  output logic              mem_wen,
  output logic              mem_men,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              init_busy,
  output logic              init_done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INIT     = 2'd1,
    S_WAIT_CFG = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_init_done;
  logic                w_init_done_nxt;
  logic                r_rd_pend;
  logic [DATA_W-1:0]   r_dout_q;
  logic                w_cnt_last;

  assign w_cnt_last = &r_cnt;

  // State, sweep counter and read-hold registers
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_dout_q    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= w_init_done_nxt;
      r_rd_pend   <= mem_men & mem_ren;
      if (r_rd_pend) begin
        r_dout_q <= mem_dout;
      end
    end
  end

  // Next state and macro drive; enables in RUN are gated by CONFIGURED in the same cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_init_done_nxt = r_init_done;
    mem_addr        = '0;
    mem_din         = '0;
    mem_bm          = '0;
    mem_wen         = 1'b0;
    mem_men         = 1'b0;
    mem_ren         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (CLEAR_ON_RESET) begin
          w_state_nxt = S_INIT;
        end else begin
          w_state_nxt     = S_WAIT_CFG;
          w_init_done_nxt = 1'b1;
        end
      end
      S_INIT: begin
        mem_addr  = r_cnt;
        mem_din   = INIT_VALUE;
        mem_bm    = '1;
        mem_wen   = 1'b1;
        mem_men   = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (w_cnt_last) begin
          w_state_nxt     = S_WAIT_CFG;
          w_init_done_nxt = 1'b1;
          w_cnt_nxt       = '0;
        end
      end
      S_WAIT_CFG: begin
        if (CONFIGURED) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        mem_addr = fab_addr;
        mem_din  = fab_din;
        mem_bm   = fab_bm;
        mem_men  = fab_men & CONFIGURED;
        mem_wen  = fab_wen & CONFIGURED;
        mem_ren  = fab_ren & CONFIGURED;
        if (!CONFIGURED) begin
          w_state_nxt = S_WAIT_CFG;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bypass fresh macro data the cycle after a read, otherwise present the held copy
  assign fab_dout  = r_rd_pend ? mem_dout : r_dout_q;
  assign init_busy = (r_state == S_INIT);
  assign init_done = r_init_done;

endmodule
